// File: rtl/gate_truth_checker_if.sv
// Bus between a truth-table sweeper and whoever owns the gate under test.
// The master requests sweeps and feeds back the gate output; the slave drives stimulus and reports.
interface gate_truth_checker_if;
    logic       start;
    logic [2:0] gate_sel;
    logic       drive_a;
    logic       drive_b;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;

    modport master (
        output start, gate_sel, dut_out,
        input  drive_a, drive_b, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        input  start, gate_sel, dut_out,
        output drive_a, drive_b, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_truth_checker.sv
// Sweeps the four {A,B} input vectors into a 2-input gate and checks its output against the selected function.
// Optional macro GATE_CHECK_ABORT_EN: stop the sweep at the first mismatching vector.
module gate_truth_checker #(
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    gate_truth_checker_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_r;
    logic [2:0] sel_r;
    logic [1:0] idx_r;
    logic [3:0] settle_r;

    logic       expect_s;
    logic       mismatch_s;
    logic       last_s;
    logic [2:0] err_next_s;
    logic [3:0] fail_next_s;

    function automatic logic gate_expect(input logic [2:0] sel, input logic a, input logic b);
        logic y;
        case (sel)
            3'd0:    y = a & b;
            3'd1:    y = a | b;
            3'd2:    y = ~(a & b);
            3'd3:    y = ~(a | b);
            3'd4:    y = a ^ b;
            3'd5:    y = ~(a ^ b);
            3'd6:    y = a;
            3'd7:    y = ~a;
            default: y = 1'b0;
        endcase
        return y;
    endfunction

    // Expected response for the vector currently held, and the verdict bookkeeping it implies.
    always_comb begin
        expect_s    = gate_expect(sel_r, idx_r[1], idx_r[0]);
        mismatch_s  = (bus.dut_out != expect_s);
        err_next_s  = bus.err_count;
        fail_next_s = bus.fail_vec;
        if (mismatch_s) begin
            err_next_s  = bus.err_count + 3'd1;
            fail_next_s = bus.fail_vec | (4'b0001 << idx_r);
        end else begin
            err_next_s  = bus.err_count;
            fail_next_s = bus.fail_vec;
        end
`ifdef GATE_CHECK_ABORT_EN
        last_s = (idx_r == 2'd3) || mismatch_s;
`else
        last_s = (idx_r == 2'd3);
`endif
    end

    // Sweep sequencer with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            sel_r         <= 3'd0;
            idx_r         <= 2'd0;
            settle_r      <= 4'd0;
            bus.drive_a   <= 1'b0;
            bus.drive_b   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.err_count <= 3'd0;
            bus.fail_vec  <= 4'd0;
        end else begin
            bus.done <= 1'b0;
            case (state_r)
                IDLE: begin
                    bus.drive_a <= 1'b0;
                    bus.drive_b <= 1'b0;
                    bus.busy    <= 1'b0;
                    if (bus.start) begin
                        sel_r         <= bus.gate_sel;
                        idx_r         <= 2'd0;
                        settle_r      <= 4'd0;
                        bus.err_count <= 3'd0;
                        bus.fail_vec  <= 4'd0;
                        bus.pass      <= 1'b0;
                        bus.busy      <= 1'b1;
                        state_r       <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_r == SETTLE_LAST) begin
                        settle_r <= 4'd0;
                        state_r  <= SAMPLE;
                    end else begin
                        settle_r <= settle_r + 4'd1;
                    end
                end
                SAMPLE: begin
                    bus.err_count <= err_next_s;
                    bus.fail_vec  <= fail_next_s;
                    if (last_s) begin
                        bus.pass    <= (err_next_s == 3'd0);
                        bus.done    <= 1'b1;
                        bus.busy    <= 1'b0;
                        bus.drive_a <= 1'b0;
                        bus.drive_b <= 1'b0;
                        state_r     <= FINISH;
                    end else begin
                        idx_r       <= idx_r + 2'd1;
                        {bus.drive_a, bus.drive_b} <= idx_r + 2'd1;
                        state_r     <= DRIVE;
                    end
                end
                FINISH: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gate_truth_checker.md
GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

Interface
REQ-001 Parameter SETTLE, default 2: number of cycles vector held before sampling; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a truth-table sweep.
REQ-005 gate_sel  input  3  expected function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 BUF(A), 7 NOT(A).
REQ-006 drive_a, drive_b  output  1 each  registered stimulus to the gate under test.
REQ-007 dut_out  input  1  gate-under-test output.
REQ-008 busy  output  1  high from the cycle after accepted start until done.
REQ-009 done  output  1  single-cycle pulse at sweep end.
REQ-010 pass  output  1  sweep verdict, valid from done until the next accepted start.
REQ-011 err_count  output  3  mismatches in the last sweep, 0..4.
REQ-012 fail_vec  output  4  bit i set when vector i mismatched; i = {A,B}.

Function
REQ-013 FSM states: IDLE, DRIVE, SAMPLE, FINISH.
REQ-014 IDLE with start=1: latch gate_sel, clear err_count/fail_vec/pass, vector index = 0, go to DRIVE.
REQ-015 start while not in IDLE is ignored; gate_sel changes after acceptance are ignored.
REQ-016 Vector order: index 0..3 -> {drive_a,drive_b} = 00, 01, 10, 11.
REQ-017 drive_a/drive_b update on the cycle the FSM enters DRIVE and hold constant through SAMPLE.
REQ-018 DRIVE lasts exactly SETTLE cycles (settle counter), then SAMPLE for exactly 1 cycle.
REQ-019 In SAMPLE: compare dut_out with expected(latched gate_sel, A, B); on mismatch increment err_count and set fail_vec[index].
REQ-020 After SAMPLE: if index<3, increment index, go to DRIVE; if index=3, go to FINISH.
REQ-021 FINISH lasts 1 cycle: done=1, busy=0, pass=(err_count==0); then IDLE.
REQ-022 Sweep latency: start accepted at cycle 0 -> done at cycle 4*(SETTLE+1)+1.
REQ-023 start asserted in the FINISH cycle is ignored; start in the first IDLE cycle after FINISH is accepted.
REQ-024 In IDLE, drive_a/drive_b return to 0; pass, err_count and fail_vec hold.
REQ-025 err_count saturates by construction at 4; no wrap.

Reset
REQ-026 rst=1 forces immediately, independent of clk: state IDLE, drive_a=0, drive_b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, index=0, settle counter=0.
REQ-027 Reset mid-sweep discards all partial results; no done pulse is emitted.
REQ-028 First start is accepted on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro GATE_CHECK_ABORT_EN defined: on first mismatch in SAMPLE, go directly to FINISH; later vectors are not driven; their fail_vec bits remain 0; err_count=1.
REQ-030 Macro GATE_CHECK_ABORT_EN undefined: all four vectors always run regardless of mismatches.

Verification
REQ-031 SETTLE=2, gate_sel=0, correct AND model, start pulse -> drive sequence 00,01,10,11 each held 3 cycles; done at cycle 13; pass=1, err_count=0, fail_vec=0000.
REQ-032 gate_sel=4 (XOR) against AND model, abort disabled -> pass=0, err_count=3, fail_vec=1110.
REQ-033 Same as REQ-032 with GATE_CHECK_ABORT_EN -> done at cycle 7 (after vector 1), err_count=1, fail_vec=0010; drive never reaches 10.
REQ-034 rst pulsed during vector 2 DRIVE -> all outputs 0 within the reset pulse, no done; new start -> clean full sweep.
REQ-035 start re-pulsed while busy and gate_sel changed to 7 mid-sweep -> no restart, verdict uses original gate_sel, done timing unchanged.
REQ-036 SETTLE=1, gate_sel=7 (NOT A), correct inverter model -> done at cycle 9, pass=1.
